// File: rtl/button_event_fsm.sv
// button_event_fsm: turns the debounced button level into press/release/short/long/repeat strobes.
// Define BUTTON_AUTO_REPEAT_EN to enable the auto-repeat counter and repeat_pulse.
module button_event_fsm #(
   parameter int LONG_COUNTS   = 25_000_000,
   parameter int REPEAT_COUNTS = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press_pulse,
   output logic release_pulse,
   output logic short_press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);
   localparam int HW = $clog2(LONG_COUNTS + 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_COUNTS - 1);
   localparam logic [1:0] IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2;

   if (LONG_COUNTS < 2 || REPEAT_COUNTS < 2) begin : g_bad_param
      $error("button_event_fsm: LONG_COUNTS and REPEAT_COUNTS must be >= 2");
   end

   logic [1:0] state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic btn_q, rise, fall;
   logic press_q, press_d, release_q, release_d, short_q, short_d, long_q, long_d;
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int RW = $clog2(REPEAT_COUNTS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_COUNTS - 1);
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic repeat_q, repeat_d;
`endif

   assign rise = btn & ~btn_q;
   assign fall = ~btn & btn_q;

   // Fall is tested before the threshold so a release on the long edge stays short.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      short_d    = 1'b0;
      long_d     = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      repeat_d   = 1'b0;
`endif
      case (state_q)
         IDLE: if (rise) begin
            state_d    = HELD;
            press_d    = 1'b1;
            hold_cnt_d = HW'(1);
         end
         HELD: if (fall) begin
            state_d   = IDLE;
            release_d = 1'b1;
            short_d   = 1'b1;
         end else if (btn) begin
            if (hold_cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
               rep_cnt_d = '0;
`endif
            end else hold_cnt_d = hold_cnt_q + 1'b1;
         end
         LONG: if (fall) begin
            state_d   = IDLE;
            release_d = 1'b1;
         end
`ifdef BUTTON_AUTO_REPEAT_EN
         else if (btn) begin
            repeat_d  = rep_cnt_q == REP_LAST;
            rep_cnt_d = repeat_d ? '0 : rep_cnt_q + 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         btn_q      <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         btn_q      <= btn;
         press_q    <= press_d;
         release_q  <= release_d;
         short_q    <= short_d;
         long_q     <= long_d;
      end
   end

`ifdef BUTTON_AUTO_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
         repeat_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         repeat_q  <= repeat_d;
      end
   end
   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_press   = short_q;
   assign long_press    = long_q;
   assign held          = state_q != IDLE;
endmodule

// File: tb/tb_button_event_fsm.sv
// tb_button_event_fsm: directed and random button traces checked cycle by cycle against an age-based model.
module tb_button_event_fsm;
   localparam int LC = 8, RC = 4;
   logic clk = 1'b0, rst_n = 1'b0, btn = 1'b0;
   logic press_pulse, release_pulse, short_press, long_press, repeat_pulse, held;
   int errors = 0, checks = 0;
   // model: whether a press is in progress, sampled cycles since its rising edge, last sampled level
   bit m_down = 0, m_prev = 0;
   int m_age = 0;
   bit e_press, e_rel, e_short, e_long, e_rep;

   button_event_fsm #(.LONG_COUNTS(LC), .REPEAT_COUNTS(RC)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .short_press(short_press),
      .long_press(long_press), .repeat_pulse(repeat_pulse), .held(held)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("press", press_pulse, e_press);
      chk("release", release_pulse, e_rel);
      chk("short", short_press, e_short);
      chk("long", long_press, e_long);
      chk("repeat", repeat_pulse, e_rep);
      chk("held", held, m_down);
   endtask

   task automatic model_clear();
      {m_down, m_prev, e_press, e_rel, e_short, e_long, e_rep} = '0;
      m_age = 0;
   endtask

   task automatic step(input bit b);
      btn = b;
      @(posedge clk);
      {e_press, e_rel, e_short, e_long, e_rep} = '0;
      if (rst_n) begin
         if (!m_down && b && !m_prev) begin
            m_down = 1; m_age = 1; e_press = 1;
         end else if (m_down && !b) begin
            m_down = 0; e_rel = 1; e_short = m_age < LC;
         end else if (m_down && b) begin
            m_age++;
            e_long = m_age == LC;
`ifdef BUTTON_AUTO_REPEAT_EN
            e_rep = m_age > LC && (m_age - LC) % RC == 0;
`endif
         end
         m_prev = b;
      end
      #1;
      chk_all();
   endtask

   task automatic steps(input bit b, input int n);
      for (int i = 0; i < n; i++) step(b);
   endtask

   // called 1 time unit after a rising edge: assert reset, check immediately, release off-edge
   task automatic async_reset(input int edges);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk_all();
      for (int i = 0; i < edges; i++) step(btn);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      model_clear();
      #2;
      chk_all();
      step(0); step(0);
      #2 rst_n = 1'b1;
      steps(0, 20);
      steps(1, 3); steps(0, 4);
      steps(1, 20); steps(0, 4);
      steps(1, 7); steps(0, 4);
      steps(1, 8); steps(0, 3);
      step(1); step(0); step(1); step(0); step(0);
      step(1); steps(0, 3);
      steps(1, 5);
      async_reset(2);
      steps(1, 12); steps(0, 3);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) async_reset($urandom_range(0, 2));
         else step($urandom_range(0, 4) == 0 ? ~btn : btn);
      end
      steps(0, 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
